// File: rtl/gdb_trigger_pkg.sv
// Shared types for the debug trigger unit: run-control commands, stop reasons,
// RSP Z-packet trigger types, the trigger slot record and the run-control FSM states.
package gdb_trigger_pkg;

  // Slot addresses are stored at the widest supported XLEN and zero-extended.
  localparam int unsigned XlenMax = 64;

  typedef enum logic [1:0] {
    CtlRun  = 2'd0,
    CtlStep = 2'd1,
    CtlHalt = 2'd2
  } ctl_cmd_t;

  typedef enum logic [2:0] {
    RsnBreak  = 3'd0,
    RsnWatch  = 3'd1,
    RsnRwatch = 3'd2,
    RsnAwatch = 3'd3,
    RsnStep   = 3'd4,
    RsnInt    = 3'd5
  } stp_rsn_t;

  typedef enum logic [2:0] {
    ZSwBrk   = 3'd0,
    ZHwBrk   = 3'd1,
    ZWrWatch = 3'd2,
    ZRdWatch = 3'd3,
    ZAcWatch = 3'd4
  } z_typ_t;

  typedef struct packed {
    logic               vld;
    z_typ_t             typ;
    logic [XlenMax-1:0] adr;
    logic [3:0]         len;
  } slot_t;

  typedef enum logic [1:0] {
    StHalted   = 2'd0,
    StRunning  = 2'd1,
    StStepping = 2'd2,
    StReport   = 2'd3
  } trigger_state_t;

  // Stop reason reported for a watchpoint slot of the given type.
  function automatic stp_rsn_t watch_rsn(input z_typ_t typ);
    case (typ)
      ZRdWatch: return RsnRwatch;
      ZAcWatch: return RsnAwatch;
      default:  return RsnWatch;
    endcase
  endfunction

endpackage

// File: rtl/gdb_trigger_slot.sv
// One trigger slot: the programmed breakpoint/watchpoint record plus its match compare.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_i, clr_i             load a new record / invalidate the record
//   wr_typ_i/adr_i/len_i    record contents for a load
//   ifu_*                   instruction fetch transfer (breakpoint compare)
//   lsu_*                   load/store transfer (watchpoint range compare)
//   slot_o                  current record, hit_o  slot matches this cycle
module gdb_trigger_slot
  import gdb_trigger_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_i,
  input  logic            clr_i,
  input  z_typ_t          wr_typ_i,
  input  logic [XLEN-1:0] wr_adr_i,
  input  logic [3:0]      wr_len_i,
  input  logic            ifu_trn_i,
  input  logic [XLEN-1:0] ifu_adr_i,
  input  logic            lsu_trn_i,
  input  logic            lsu_wen_i,
  input  logic [XLEN-1:0] lsu_adr_i,
  input  logic [1:0]      lsu_siz_i,
  output slot_t           slot_o,
  output logic            hit_o
);

  slot_t slot_d, slot_q;
  // Delays arming by one cycle so a fresh slot matches only after its cfg_ack cycle.
  logic armed_q;

  logic [XLEN-1:0] adr;
  logic [XLEN:0]   lsu_end, slot_end;
  logic            dir_ok, overlap, is_brk;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d.vld = 1'b0;
    end else if (wr_i) begin
      slot_d.vld = 1'b1;
      slot_d.typ = wr_typ_i;
      slot_d.adr = XlenMax'(wr_adr_i);
      slot_d.len = wr_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      armed_q <= slot_q.vld;
    end
  end

  // Range ends carry one extra bit so ranges never wrap past the top of memory.
  assign adr      = slot_q.adr[XLEN-1:0];
  assign lsu_end  = {1'b0, lsu_adr_i} + ((XLEN+1)'(1) << lsu_siz_i);
  assign slot_end = {1'b0, adr} + (XLEN+1)'(slot_q.len);
  assign overlap  = ({1'b0, lsu_adr_i} < slot_end) && ({1'b0, adr} < lsu_end);
  assign is_brk   = (slot_q.typ == ZSwBrk) || (slot_q.typ == ZHwBrk);

  always_comb begin
    case (slot_q.typ)
      ZWrWatch: dir_ok = lsu_wen_i;
      ZRdWatch: dir_ok = !lsu_wen_i;
      ZAcWatch: dir_ok = 1'b1;
      default:  dir_ok = 1'b0;
    endcase
  end

  assign hit_o  = slot_q.vld && armed_q &&
                  (is_brk ? (ifu_trn_i && (ifu_adr_i == adr))
                          : (lsu_trn_i && dir_ok && overlap));
  assign slot_o = slot_q;

endmodule

// File: rtl/gdb_trigger_unit.sv
// Run-control and trigger stage between the core and the GDB server stub.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   cfg_*                    Z/z slot insert/remove request, registered ack/err
//   ctl_vld_i, ctl_cmd_i     RUN / STEP / HALT command
//   cpu_run_o                core may advance
//   ifu_*, lsu_*             monitored fetch and load/store transfers
//   stp_vld_o/rsn_o/adr_o    stop report held until stp_ack_i
module gdb_trigger_unit
  import gdb_trigger_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NBRK = 4,
  parameter int unsigned NWCH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_vld_i,
  input  logic            cfg_ins_i,
  input  logic [2:0]      cfg_typ_i,
  input  logic [XLEN-1:0] cfg_adr_i,
  input  logic [3:0]      cfg_len_i,
  output logic            cfg_ack_o,
  output logic            cfg_err_o,
  input  logic            ctl_vld_i,
  input  logic [1:0]      ctl_cmd_i,
  output logic            cpu_run_o,
  input  logic            ifu_trn_i,
  input  logic [XLEN-1:0] ifu_adr_i,
  input  logic            lsu_trn_i,
  input  logic            lsu_wen_i,
  input  logic [XLEN-1:0] lsu_adr_i,
  input  logic [1:0]      lsu_siz_i,
  output logic            stp_vld_o,
  output logic [2:0]      stp_rsn_o,
  output logic [XLEN-1:0] stp_adr_o,
  input  logic            stp_ack_i
);

  localparam int unsigned NSLOT = NBRK + NWCH;

  slot_t [NSLOT-1:0] slots;
  logic  [NSLOT-1:0] hit, wr_sel, clr_sel, in_class, same;
  logic              is_brk, is_bad, any_same, free_found, cfg_err_d;
  logic              cfg_ack_q, cfg_err_q;
  z_typ_t            cfg_typ;
  ctl_cmd_t          ctl_cmd;

  logic              brk_any, wch_any, stop_now;
  stp_rsn_t          wch_rsn, stop_rsn;
  logic [XLEN-1:0]   wch_adr, stop_adr;

  trigger_state_t    state_q;
  logic              cpu_run_q, stp_vld_q;
  stp_rsn_t          stp_rsn_q;
  logic [XLEN-1:0]   stp_adr_q;

  assign cfg_typ = z_typ_t'(cfg_typ_i);
  assign ctl_cmd = ctl_cmd_t'(ctl_cmd_i);

  // Slots [0, NBRK) are breakpoints, [NBRK, NSLOT) are watchpoints.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    gdb_trigger_slot #(
      .XLEN(XLEN)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_i     (wr_sel[g]),
      .clr_i    (clr_sel[g]),
      .wr_typ_i (cfg_typ),
      .wr_adr_i (cfg_adr_i),
      .wr_len_i (cfg_len_i),
      .ifu_trn_i(ifu_trn_i),
      .ifu_adr_i(ifu_adr_i),
      .lsu_trn_i(lsu_trn_i),
      .lsu_wen_i(lsu_wen_i),
      .lsu_adr_i(lsu_adr_i),
      .lsu_siz_i(lsu_siz_i),
      .slot_o   (slots[g]),
      .hit_o    (hit[g])
    );
  end

  // Slot allocation: exact-match search plus lowest free slot of the request's class.
  always_comb begin
    is_brk     = (cfg_typ_i <= 3'd1);
    is_bad     = (cfg_typ_i > 3'd4);
    in_class   = '0;
    same       = '0;
    wr_sel     = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      in_class[i] = (i < NBRK) ? is_brk : (!is_brk && !is_bad);
      // Breakpoint length is meaningless, so it takes no part in the match.
      same[i] = in_class[i] && slots[i].vld && (slots[i].typ == cfg_typ) &&
                (slots[i].adr == XlenMax'(cfg_adr_i)) &&
                (is_brk || (slots[i].len == cfg_len_i));
      if (in_class[i] && !slots[i].vld && !free_found) begin
        free_found = 1'b1;
        wr_sel[i]  = 1'b1;
      end
    end
    any_same = |same;
    if (!cfg_vld_i || !cfg_ins_i || any_same) wr_sel = '0;
    clr_sel   = (cfg_vld_i && !cfg_ins_i) ? same : '0;
    cfg_err_d = !(any_same || (cfg_ins_i && free_found));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_vld_i;
      cfg_err_q <= cfg_vld_i && cfg_err_d;
    end
  end

  // Stop priority: BREAK > WATCH (lowest slot) > STEP > INT.
  always_comb begin
    brk_any = |hit[NBRK-1:0];
    wch_any = 1'b0;
    wch_rsn = RsnWatch;
    wch_adr = '0;
    for (int unsigned i = NBRK; i < NSLOT; i++) begin
      if (hit[i] && !wch_any) begin
        wch_any = 1'b1;
        wch_rsn = watch_rsn(slots[i].typ);
        wch_adr = slots[i].adr[XLEN-1:0];
      end
    end

    stop_now = 1'b1;
    stop_rsn = RsnBreak;
    stop_adr = ifu_adr_i;
    if (brk_any) begin
      stop_rsn = RsnBreak;
    end else if (wch_any) begin
      stop_rsn = wch_rsn;
      stop_adr = wch_adr;
    end else if ((state_q == StStepping) && ifu_trn_i) begin
      stop_rsn = RsnStep;
    end else if (ctl_vld_i && (ctl_cmd == CtlHalt)) begin
      stop_rsn = RsnInt;
    end else begin
      stop_now = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StHalted;
      cpu_run_q <= 1'b0;
      stp_vld_q <= 1'b0;
      stp_rsn_q <= RsnBreak;
      stp_adr_q <= '0;
    end else begin
      unique case (state_q)
        StHalted: begin
          if (ctl_vld_i && (ctl_cmd == CtlRun)) begin
            state_q   <= StRunning;
            cpu_run_q <= 1'b1;
          end else if (ctl_vld_i && (ctl_cmd == CtlStep)) begin
            state_q   <= StStepping;
            cpu_run_q <= 1'b1;
          end
        end
        StRunning, StStepping: begin
          if (stop_now) begin
            state_q   <= StReport;
            cpu_run_q <= 1'b0;
            stp_vld_q <= 1'b1;
            stp_rsn_q <= stop_rsn;
            stp_adr_q <= stop_adr;
          end
        end
        StReport: begin
          if (stp_ack_i) begin
            state_q   <= StHalted;
            stp_vld_q <= 1'b0;
          end
        end
        default: state_q <= StHalted;
      endcase
    end
  end

  assign cfg_ack_o = cfg_ack_q;
  assign cfg_err_o = cfg_err_q;
  assign cpu_run_o = cpu_run_q;
  assign stp_vld_o = stp_vld_q;
  assign stp_rsn_o = stp_rsn_q;
  assign stp_adr_o = stp_adr_q;

endmodule

// File: tb/tb_gdb_trigger_unit.sv
// Scoreboard bench for gdb_trigger_unit: directed stimulus pushes expected cfg
// and stop responses into queues; a negedge monitor pops and compares them.
module tb_gdb_trigger_unit;

  localparam logic [2:0] RBreak  = 3'd0;
  localparam logic [2:0] RWatch  = 3'd1;
  localparam logic [2:0] RAwatch = 3'd3;
  localparam logic [2:0] RStep   = 3'd4;
  localparam logic [2:0] RInt    = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_vld, cfg_ins;
  logic [2:0]  cfg_typ;
  logic [31:0] cfg_adr;
  logic [3:0]  cfg_len;
  logic        cfg_ack, cfg_err;
  logic        ctl_vld;
  logic [1:0]  ctl_cmd;
  logic        cpu_run;
  logic        ifu_trn;
  logic [31:0] ifu_adr;
  logic        lsu_trn, lsu_wen;
  logic [31:0] lsu_adr;
  logic [1:0]  lsu_siz;
  logic        stp_vld;
  logic [2:0]  stp_rsn;
  logic [31:0] stp_adr;
  logic        stp_ack;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        cfg_exp[$];
  logic [34:0] stp_exp[$];
  logic        stp_prev = 1'b0;

  always #5 clk = ~clk;

  gdb_trigger_unit #(
    .XLEN(32),
    .NBRK(4),
    .NWCH(2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cfg_vld_i(cfg_vld),
    .cfg_ins_i(cfg_ins),
    .cfg_typ_i(cfg_typ),
    .cfg_adr_i(cfg_adr),
    .cfg_len_i(cfg_len),
    .cfg_ack_o(cfg_ack),
    .cfg_err_o(cfg_err),
    .ctl_vld_i(ctl_vld),
    .ctl_cmd_i(ctl_cmd),
    .cpu_run_o(cpu_run),
    .ifu_trn_i(ifu_trn),
    .ifu_adr_i(ifu_adr),
    .lsu_trn_i(lsu_trn),
    .lsu_wen_i(lsu_wen),
    .lsu_adr_i(lsu_adr),
    .lsu_siz_i(lsu_siz),
    .stp_vld_o(stp_vld),
    .stp_rsn_o(stp_rsn),
    .stp_adr_o(stp_adr),
    .stp_ack_i(stp_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input bit ins, input logic [2:0] typ, input logic [31:0] adr,
                     input logic [3:0] len, input bit err);
    cfg_exp.push_back(err);
    cfg_vld = 1'b1; cfg_ins = ins; cfg_typ = typ; cfg_adr = adr; cfg_len = len;
    step();
    cfg_vld = 1'b0;
    step();
  endtask

  task automatic ctl(input logic [1:0] cmd);
    ctl_vld = 1'b1; ctl_cmd = cmd;
    step();
    ctl_vld = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    ifu_trn = 1'b1; ifu_adr = pc;
    step();
    ifu_trn = 1'b0;
  endtask

  task automatic mem(input bit wen, input logic [31:0] adr, input logic [1:0] siz);
    lsu_trn = 1'b1; lsu_wen = wen; lsu_adr = adr; lsu_siz = siz;
    step();
    lsu_trn = 1'b0;
  endtask

  task automatic expect_stop(input logic [2:0] rsn, input logic [31:0] adr);
    stp_exp.push_back({rsn, adr});
  endtask

  // Wait (bounded) for a stop report, acknowledge it and confirm it clears.
  task automatic ack_stop();
    int n = 0;
    while (!stp_vld && n < 10) begin
      step();
      n++;
    end
    chk("stop_present", stp_vld, 1);
    stp_ack = 1'b1;
    step();
    stp_ack = 1'b0;
    @(negedge clk);
    chk("stop_cleared", stp_vld, 0);
  endtask

  // Monitor: every cfg_ack and every new stop report is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (cfg_ack) begin
        if (cfg_exp.size() == 0) chk("cfg_ack_unexpected", cfg_ack, 0);
        else chk("cfg_err", cfg_err, cfg_exp.pop_front());
      end
      if (stp_vld && !stp_prev) begin
        if (stp_exp.size() == 0) chk("stp_unexpected", stp_vld, 0);
        else chk("stp_report", {stp_rsn, stp_adr}, stp_exp.pop_front());
      end
      stp_prev = stp_vld;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_vld = 1'b0; cfg_ins = 1'b0; cfg_typ = '0; cfg_adr = '0; cfg_len = '0;
    ctl_vld = 1'b0; ctl_cmd = '0;
    ifu_trn = 1'b0; ifu_adr = '0;
    lsu_trn = 1'b0; lsu_wen = 1'b0; lsu_adr = '0; lsu_siz = '0;
    stp_ack = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_stp_vld", stp_vld, 0);
    chk("rst_stp_rsn", stp_rsn, 0);
    chk("rst_stp_adr", stp_adr, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_cfg_err", cfg_err, 0);
    step();
    rst = 1'b0;
    step();

    // RUN: cpu_run rises one cycle after the command, free-running PCs raise nothing.
    ctl_vld = 1'b1; ctl_cmd = 2'd0;
    @(negedge clk);
    chk("run_cpu_run_same", cpu_run, 0);
    step();
    ctl_vld = 1'b0;
    @(negedge clk);
    chk("run_cpu_run_next", cpu_run, 1);
    step();
    for (int i = 0; i < 8; i++) fetch(32'h8000_0000 + 32'(4 * i));
    // HALT while running -> INT at the current fetch address.
    expect_stop(RInt, 32'h8000_0020);
    ifu_trn = 1'b1; ifu_adr = 32'h8000_0020; ctl_vld = 1'b1; ctl_cmd = 2'd2;
    step();
    ifu_trn = 1'b0; ctl_vld = 1'b0;
    @(negedge clk);
    chk("int_cpu_run", cpu_run, 0);
    ack_stop();

    // Hardware breakpoint, hit latency and report stability.
    cfg(1'b1, 3'd1, 32'h8000_0010, 4'd1, 1'b0);
    ctl(2'd0);
    expect_stop(RBreak, 32'h8000_0010);
    for (int i = 0; i < 4; i++) fetch(32'h8000_0000 + 32'(4 * i));
    ifu_trn = 1'b1; ifu_adr = 32'h8000_0010;
    @(negedge clk);
    chk("brk_hit_cycle_run", cpu_run, 1);
    step();
    ifu_trn = 1'b0;
    @(negedge clk);
    chk("brk_stall", cpu_run, 0);
    for (int i = 0; i < 5; i++) begin
      chk("brk_hold", {stp_vld, stp_rsn, stp_adr}, {1'b1, RBreak, 32'h8000_0010});
      @(negedge clk);
    end
    ack_stop();

    // Slot allocation corner cases.
    cfg(1'b1, 3'd0, 32'h8000_0040, 4'd1, 1'b0);
    cfg(1'b1, 3'd0, 32'h8000_0044, 4'd1, 1'b0);
    cfg(1'b1, 3'd1, 32'h8000_0048, 4'd1, 1'b0);
    cfg(1'b1, 3'd0, 32'h8000_004C, 4'd1, 1'b1);  // all four breakpoint slots taken
    cfg(1'b0, 3'd0, 32'h0000_1234, 4'd1, 1'b1);  // remove of absent slot
    cfg(1'b1, 3'd1, 32'h8000_0010, 4'd1, 1'b0);  // duplicate while full
    cfg(1'b1, 3'd5, 32'h8000_0050, 4'd1, 1'b1);  // illegal type
    cfg(1'b0, 3'd1, 32'h8000_0010, 4'd1, 1'b0);
    cfg(1'b0, 3'd1, 32'h8000_0010, 4'd1, 1'b1);  // duplicate did not take a second slot

    // Watchpoints: write watch [0x8000_0100, +4) and access watch at the top of memory.
    cfg(1'b1, 3'd2, 32'h8000_0100, 4'd4, 1'b0);
    cfg(1'b1, 3'd4, 32'hFFFF_FFFE, 4'd4, 1'b0);
    ctl(2'd0);
    expect_stop(RWatch, 32'h8000_0100);
    mem(1'b1, 32'h8000_0103, 2'd0);
    @(negedge clk);
    chk("wch_stall", cpu_run, 0);
    ack_stop();
    ctl(2'd0);
    mem(1'b0, 32'h8000_0103, 2'd0);  // load on a write watch
    mem(1'b1, 32'h8000_0104, 2'd0);  // just past the end
    mem(1'b1, 32'h8000_00FC, 2'd2);  // ends just before the start
    mem(1'b0, 32'h0000_0000, 2'd2);  // would hit only if the top range wrapped
    expect_stop(RWatch, 32'h8000_0100);
    mem(1'b1, 32'h8000_00FF, 2'd1);  // straddles the start
    ack_stop();
    ctl(2'd0);
    expect_stop(RAwatch, 32'hFFFF_FFFE);
    mem(1'b0, 32'hFFFF_FFFF, 2'd0);
    ack_stop();

    // Single step: exactly one transfer then a STEP report.
    ctl(2'd1);
    expect_stop(RStep, 32'h8000_0000);
    fetch(32'h8000_0000);
    @(negedge clk);
    chk("step_stall", cpu_run, 0);
    ack_stop();

    // Breakpoint and watchpoint in the same cycle: BREAK wins.
    ctl(2'd0);
    expect_stop(RBreak, 32'h8000_0040);
    ifu_trn = 1'b1; ifu_adr = 32'h8000_0040;
    lsu_trn = 1'b1; lsu_wen = 1'b1; lsu_adr = 32'h8000_0100; lsu_siz = 2'd0;
    step();
    ifu_trn = 1'b0; lsu_trn = 1'b0;
    ack_stop();

    // Reset during a report with a config request in flight.
    ctl(2'd0);
    expect_stop(RBreak, 32'h8000_0044);
    fetch(32'h8000_0044);
    @(negedge clk);
    chk("pre_rst_stp_vld", stp_vld, 1);
    rst = 1'b1;
    cfg_vld = 1'b1; cfg_ins = 1'b1; cfg_typ = 3'd0; cfg_adr = 32'h8000_0050; cfg_len = 4'd1;
    step();
    rst = 1'b0; cfg_vld = 1'b0;
    @(negedge clk);
    chk("rst2_cpu_run", cpu_run, 0);
    chk("rst2_stp_vld", stp_vld, 0);
    chk("rst2_stp_rsn", stp_rsn, 0);
    chk("rst2_stp_adr", stp_adr, 0);
    chk("rst2_cfg_ack", cfg_ack, 0);
    chk("rst2_cfg_err", cfg_err, 0);
    step();
    ctl(2'd0);
    @(negedge clk);
    chk("rst2_run", cpu_run, 1);
    step();
    fetch(32'h8000_0044);
    fetch(32'h8000_0040);
    fetch(32'h8000_0050);
    mem(1'b1, 32'h8000_0103, 2'd0);
    expect_stop(RInt, 32'h8000_0060);
    ifu_trn = 1'b1; ifu_adr = 32'h8000_0060; ctl_vld = 1'b1; ctl_cmd = 2'd2;
    step();
    ifu_trn = 1'b0; ctl_vld = 1'b0;
    ack_stop();

    repeat (3) step();
    chk("cfg_exp_drained", cfg_exp.size(), 0);
    chk("stp_exp_drained", stp_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
